// File: rtl/axi_r_drain.sv
// AXI read-data drain: pops a first-word-fall-through FIFO into R-channel beats for one burst command.
// Optional build macro AXI_R_DRAIN_ERR_EN: map the FIFO error tag onto rresp (SLVERR); otherwise rresp is OKAY.
module axi_r_drain #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [7:0]        cmd_len,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_re,
  input  logic              fifo_rerr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [ID_W-1:0]   rid,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [8:0]          cnt_q, cnt_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                rlast_q, rlast_d;

  logic accept;
  logic load;
  logic last_hs;

  // cnt_q counts beats already loaded; it is 9 bits so a 256-beat burst ends at 256 without wrapping.
  assign accept  = cmd_valid & cmd_ready;
  assign load    = (state_q == BURST) & ~fifo_empty & (~rvalid_q | rready)
                   & (cnt_q <= {1'b0, len_q}) & ~rst;
  assign last_hs = rvalid_q & rready & rlast_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? BURST : IDLE;
      BURST:   state_d = last_hs ? IDLE : BURST;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    cmd_ready = ~rst;
      BURST:   busy      = 1'b1;
      default: begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
      end
    endcase
    fifo_re = load;
  end

  always_comb begin
    id_d     = id_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rid_d    = rid_q;
    rlast_d  = rlast_q;
    if (accept) begin
      id_d  = cmd_id;
      len_d = cmd_len;
      cnt_d = 9'd0;
    end else if (load) begin
      cnt_d = cnt_q + 9'd1;
    end else begin
      cnt_d = cnt_q;
    end
    if (load) begin
      rvalid_d = 1'b1;
      rdata_d  = fifo_rdata;
      rid_d    = id_q;
      rlast_d  = (cnt_q == {1'b0, len_q});
    end else if (rvalid_q & rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

`ifdef AXI_R_DRAIN_ERR_EN
  always_comb begin
    rresp_d = rresp_q;
    if (load) begin
      rresp_d = fifo_rerr ? 2'b10 : 2'b00;
    end else begin
      rresp_d = rresp_q;
    end
  end
`else
  logic unused_rerr;
  assign unused_rerr = fifo_rerr;
  assign rresp_d     = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      len_q    <= 8'd0;
      cnt_q    <= 9'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rresp_q  <= 2'b00;
      rlast_q  <= 1'b0;
    end else begin
      id_q     <= id_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rid_q    <= rid_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rid    = rid_q;
  assign rresp  = rresp_q;
  assign rlast  = rlast_q;

endmodule

// File: tb/tb_axi_r_drain.sv
// Bench for axi_r_drain: FIFO and expected beats are modelled as queues; directed and random bursts.
module tb_axi_r_drain;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_id;
  logic [7:0]    cmd_len;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_re;
  logic          fifo_rerr;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [IW-1:0] rid;
  logic [1:0]    rresp;
  logic          rlast;
  logic          busy;

  always #5 clk = ~clk;

  axi_r_drain #(.DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_id(cmd_id), .cmd_len(cmd_len), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_re(fifo_re), .fifo_rerr(fifo_rerr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
    .rresp(rresp), .rlast(rlast), .busy(busy)
  );

  logic [DW-1:0] fq_data[$];
  logic          fq_err[$];
  logic [DW-1:0] exp_data[$], got_data[$];
  logic [IW-1:0] exp_id[$],   got_id[$];
  logic [1:0]    exp_resp[$], got_resp[$];
  logic          exp_last[$], got_last[$];
  int            hs_cyc[$];

  int   nchk = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   pops = 0;
  int   acc_cyc = 0;
  int   rready_mode = 2;   // 0: always ready, 1: random, 2: driven by the scenario
  bit   empty_rand = 1'b0;
  logic stall_empty = 1'b0;
  bit   prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_id;
  logic [1:0]    prev_resp;
  logic          prev_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo();
    fifo_empty = stall_empty || (fq_data.size() == 0);
    if (fq_data.size() > 0) begin
      fifo_rdata = fq_data[0];
      fifo_rerr  = fq_err[0];
    end else begin
      fifo_rdata = '0;
      fifo_rerr  = 1'b0;
    end
  endtask

  // One clock: drive inputs, sample at negedge, apply the FIFO pop after the rising edge.
  task automatic step();
    logic re;
    if (rready_mode == 1) rready = ($urandom_range(0, 2) != 0);
    else if (rready_mode == 0) rready = 1'b1;
    if (empty_rand) stall_empty = ($urandom_range(0, 3) == 0);
    update_fifo();
    #1;
    if (prev_stall) begin
      check("hold_valid", rvalid, 1);
      check("hold_data", rdata, prev_data);
      check("hold_id", rid, prev_id);
      check("hold_resp", rresp, prev_resp);
      check("hold_last", rlast, prev_last);
    end
    if (rvalid && !rready && !rst) check("stall_re", fifo_re, 0);
    prev_stall = rvalid && !rready && !rst;
    prev_data = rdata; prev_id = rid; prev_resp = rresp; prev_last = rlast;
    re = fifo_re;
    if (re) begin
      check("pop_nonempty", fifo_empty, 0);
      pops++;
    end
    if (rvalid && rready && !rst) begin
      got_data.push_back(rdata); got_id.push_back(rid);
      got_resp.push_back(rresp); got_last.push_back(rlast);
      hs_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (re && fq_data.size() > 0) begin
      void'(fq_data.pop_front());
      void'(fq_err.pop_front());
    end
    update_fifo();
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_all();
    fq_data.delete(); fq_err.delete();
    exp_data.delete(); exp_id.delete(); exp_resp.delete(); exp_last.delete();
    got_data.delete(); got_id.delete(); got_resp.delete(); got_last.delete();
    hs_cyc.delete();
    pops = 0;
    update_fifo();
  endtask

  task automatic load_burst(input logic [IW-1:0] id, input int len, input int err_idx, input int extra);
    logic [DW-1:0] w;
    for (int i = 0; i <= len + extra; i++) begin
      w = $urandom;
      fq_data.push_back(w);
      fq_err.push_back(i == err_idx);
      if (i <= len) begin
        exp_data.push_back(w);
        exp_id.push_back(id);
`ifdef AXI_R_DRAIN_ERR_EN
        exp_resp.push_back((i == err_idx) ? 2'b10 : 2'b00);
`else
        exp_resp.push_back(2'b00);
`endif
        exp_last.push_back(i == len);
      end
    end
    update_fifo();
  endtask

  task automatic start_burst(input logic [IW-1:0] id, input int len);
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_len   = len[7:0];
    #1;
    check("cmd_ready_idle", cmd_ready, 1);
    acc_cyc = cyc;
    step();
    cmd_valid = 1'b0;
    check("busy_start", busy, 1);
    check("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (got_data.size() < exp_data.size() && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic compare_beats();
    check("beat_count", got_data.size(), exp_data.size());
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      check("rdata", got_data[i], exp_data[i]);
      check("rid", got_id[i], exp_id[i]);
      check("rresp", got_resp[i], exp_resp[i]);
      check("rlast", got_last[i], exp_last[i]);
    end
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_rvalid", rvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, eidx, extra, n;
    logic [IW-1:0] id;
    rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_len = 8'd0; rready = 1'b0;
    update_fifo();
    @(negedge clk);
    #1;
    check("rst_fifo_re", fifo_re, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    step();
    step();
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rid", rid, 0);
    check("rst_rresp", rresp, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1);

    // len=3, four words ready, two extra words that must stay in the FIFO
    clear_all(); rready_mode = 0;
    load_burst(4'h3, 3, -1, 2);
    start_burst(4'h3, 3);
    wait_done(50);
    compare_beats();
    check("s1_pops", pops, 4);
    check("s1_left", fq_data.size(), 2);
    if (hs_cyc.size() == 4) begin
      check("s1_latency", hs_cyc[0] - acc_cyc, 2);
      check("s1_consecutive", hs_cyc[3] - hs_cyc[0], 3);
    end
    step();
    check("s1_no_re_after", fifo_re, 0);

    // len=1 with a three-cycle stall on the first beat
    clear_all(); rready_mode = 2; rready = 1'b0;
    load_burst(4'h5, 1, -1, 0);
    start_burst(4'h5, 1);
    n = 0;
    while (!rvalid && n < 10) begin step(); n++; end
    check("s2_first_valid", rvalid, 1);
    check("s2_first_data", rdata, exp_data[0]);
    for (int k = 0; k < 3; k++) begin
      step();
      check("s2_stall_re", fifo_re, 0);
      check("s2_stall_data", rdata, exp_data[0]);
    end
    rready = 1'b1;
    #1;
    check("s2_reload_re", fifo_re, 1);
    step();
    check("s2_second_valid", rvalid, 1);
    check("s2_second_data", rdata, exp_data[1]);
    check("s2_second_last", rlast, 1);
    wait_done(20);
    compare_beats();
    check("s2_pops", pops, 2);

    // len=0 behind an empty FIFO for five cycles
    clear_all(); rready_mode = 0; stall_empty = 1'b1;
    load_burst(4'h6, 0, -1, 0);
    start_burst(4'h6, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("s3_wait_rvalid", rvalid, 0);
      check("s3_wait_re", fifo_re, 0);
    end
    stall_empty = 1'b0;
    update_fifo();
    #1;
    check("s3_re", fifo_re, 1);
    step();
    check("s3_rvalid", rvalid, 1);
    check("s3_rlast", rlast, 1);
    check("s3_rdata", rdata, exp_data[0]);
    wait_done(10);
    compare_beats();

    // len=255: 256 beats with no wrap, one extra word left behind
    clear_all(); rready_mode = 0;
    load_burst(4'h9, 255, -1, 1);
    start_burst(4'h9, 255);
    wait_done(400);
    compare_beats();
    check("s4_pops", pops, 256);
    check("s4_left", fq_data.size(), 1);
    if (hs_cyc.size() == 256) check("s4_consecutive", hs_cyc[255] - hs_cyc[0], 255);

    // reset while beat 2 of a len=7 burst is presented
    clear_all(); rready_mode = 0;
    load_burst(4'h7, 7, -1, 0);
    start_burst(4'h7, 7);
    n = 0;
    while (got_data.size() < 1 && n < 20) begin step(); n++; end
    check("s5_beat2_valid", rvalid, 1);
    rst = 1'b1;
    #1;
    check("s5_rst_re", fifo_re, 0);
    check("s5_rst_cmd_ready", cmd_ready, 0);
    step();
    check("s5_rvalid", rvalid, 0);
    check("s5_busy", busy, 0);
    check("s5_rlast", rlast, 0);
    rst = 1'b0;
    #1;
    check("s5_cmd_ready", cmd_ready, 1);
    step();
    check("s5_stays_idle", rvalid, 0);

    // error tag on beat 1 of a len=2 burst
    clear_all(); rready_mode = 0;
    load_burst(4'h2, 2, 1, 0);
    start_burst(4'h2, 2);
    wait_done(20);
    compare_beats();

    // random bursts with random back-pressure and FIFO underrun
    for (int t = 0; t < 6; t++) begin
      clear_all(); rready_mode = 1; empty_rand = 1'b1;
      len   = $urandom_range(0, 12);
      eidx  = $urandom_range(0, len);
      extra = $urandom_range(0, 2);
      id    = 4'($urandom);
      load_burst(id, len, eidx, extra);
      start_burst(id, len);
      wait_done(300);
      compare_beats();
      check("rand_pops", pops, len + 1);
      check("rand_left", fq_data.size(), extra);
      empty_rand = 1'b0; stall_empty = 1'b0;
      rready_mode = 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/axi_r_drain.md
AXI_R_DRAIN -- requirements
Module: axi_r_drain

Interface
REQ-001 SHALL have parameter DATA_W, default 32: R-channel and FIFO data width in bits.
REQ-002 SHALL have parameter ID_W, default 4: AXI ID width in bits.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1: read burst command offered.
REQ-006 SHALL have port cmd_ready  output  1: command accepted when cmd_valid and cmd_ready are both 1 on an edge.
REQ-007 SHALL have port cmd_id  input  ID_W: ID returned on every beat of the burst.
REQ-008 SHALL have port cmd_len  input  8: AXI length; beats = cmd_len+1.
REQ-009 SHALL have port fifo_empty  input  1: source FIFO empty flag.
REQ-010 SHALL have port fifo_rdata  input  DATA_W: word at the FIFO read pointer; first-word-fall-through, valid while fifo_empty=0.
REQ-011 SHALL have port fifo_re  output  1: pop strobe; the FIFO advances its read pointer on an edge where fifo_re=1.
REQ-012 SHALL have port fifo_rerr  input  1: error tag of the word at the read pointer.
REQ-013 SHALL have ports rvalid output 1, rready input 1, rdata output DATA_W, rid output ID_W, rresp output 2, rlast output 1: AXI R channel.
REQ-014 SHALL have port busy  output  1: high while a burst is in progress.

Function
REQ-015 SHALL implement states IDLE and BURST.
REQ-016 In IDLE, cmd_ready SHALL be 1; in BURST, cmd_ready SHALL be 0.
REQ-017 On cmd_valid&cmd_ready, the block SHALL latch cmd_id and cmd_len, clear the beat counter to 0, and enter BURST on the next cycle.
REQ-018 load = BURST & ~fifo_empty & (~rvalid | rready) & (beats issued <= len); fifo_re SHALL equal load combinationally.
REQ-019 On a load edge, the block SHALL register rdata=fifo_rdata, rid=latched id, rlast=(beat counter==len), and rvalid=1, then increment the beat counter.
REQ-020 Latency from fifo_empty falling (BURST, output register free) to rvalid=1 SHALL be 1 cycle.
REQ-021 Throughput SHALL be one beat per cycle while rready=1 and fifo_empty=0; no bubble on consecutive beats.
REQ-022 While rvalid=1 and rready=0, rdata, rid, rresp and rlast SHALL hold stable, and fifo_re SHALL be 0.
REQ-023 On rvalid&rready with no load on the same edge, rvalid SHALL clear to 0.
REQ-024 On rvalid&rready&rlast, the block SHALL return to IDLE; cmd_ready SHALL be 1 on the next cycle.
REQ-025 After the last beat is loaded, fifo_re SHALL stay 0 until the next burst, even if fifo_empty=0.
REQ-026 When fifo_empty=1 during BURST, the block SHALL wait with no timeout; fifo_re SHALL be 0.
REQ-027 The beat counter SHALL be 9 bits so that cmd_len=255 (256 beats) does not wrap.
REQ-028 busy SHALL be 1 from the cycle after command acceptance through the cycle the last beat handshakes.

Reset
REQ-029 With rst=1 on an edge, the block SHALL reset to: state IDLE, rvalid=0, rlast=0, rdata=0, rid=0, rresp=0, beat counter=0, busy=0.
REQ-030 During rst=1, fifo_re SHALL be 0 and cmd_ready SHALL be 0.
REQ-031 Reset mid-burst SHALL abandon the burst without completing rlast; FIFO pointer recovery is the FIFO owner's responsibility.

Configuration
REQ-032 With macro AXI_R_DRAIN_ERR_EN defined, rresp SHALL be registered on load as 2'b10 (SLVERR) when fifo_rerr=1, else 2'b00.
REQ-033 With AXI_R_DRAIN_ERR_EN undefined, rresp SHALL be constant 2'b00, and fifo_rerr SHALL be ignored.

Verification
REQ-034 A bench SHALL cover: len=3, FIFO holds 4 words A0..A3, rready=1 -> rvalid high 4 consecutive cycles; rdata=A0..A3; rlast only on A3; 4 fifo_re pulses; IDLE after.
REQ-035 A bench SHALL cover: len=1, rready=0 for 3 cycles after first rvalid -> rdata held, fifo_re=0 during stall, second beat follows 1 cycle after rready rises.
REQ-036 A bench SHALL cover: len=0 with fifo_empty=1 for 5 cycles, then 0 -> rvalid 1 cycle after empty falls; rlast=1 on that single beat.
REQ-037 A bench SHALL cover: len=255, continuous data -> 256 beats, rlast on beat 256 only, counter does not wrap.
REQ-038 A bench SHALL cover: rst asserted on beat 2 of a len=7 burst -> next cycle rvalid=0, busy=0, cmd_ready=1 once rst is released.
REQ-039 A bench SHALL cover: with AXI_R_DRAIN_ERR_EN, fifo_rerr=1 on beat 1 of len=2 -> rresp=2'b10 on beat 1 only; without the macro, rresp=2'b00 on all beats.
